// File: rtl/commit_trace_buf.sv
// Retirement trace FIFO: captures every ROB commit with a sequence number and drains it over valid/ready.
// Optional per-entry capture-cycle stamp enabled by defining COMMIT_TRACE_CYCLE_EN.
module commit_trace_buf #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16,
  parameter int OVF_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [4:0]               commit_rd,
  input  logic [31:0]              commit_data,
  input  logic [2:0]               commit_tag,
  input  logic                     commit_is_store,
  input  logic                     trace_freeze,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_pc,
  output logic [4:0]               trace_rd,
  output logic [31:0]              trace_data,
  output logic [2:0]               trace_tag,
  output logic                     trace_is_store,
  output logic [SEQ_W-1:0]         trace_seq,
`ifdef COMMIT_TRACE_CYCLE_EN
  output logic [31:0]              trace_cycle,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [OVF_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [2:0]       tag;
    logic             is_store;
    logic [SEQ_W-1:0] seq;
`ifdef COMMIT_TRACE_CYCLE_EN
    logic [31:0]      cycle;
`endif
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head_entry;
  logic [AW-1:0]    head, tail;
  logic [SEQ_W-1:0] seq_q;
  logic             pop, accept, drop;
`ifdef COMMIT_TRACE_CYCLE_EN
  logic [31:0]      cycle_q;
`endif

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign pop    = !empty && trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign accept = commit_valid && !trace_freeze && (!full || pop);
  assign drop   = commit_valid && !accept;

  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = commit_pc;
    wr_entry.rd       = commit_rd;
    wr_entry.data     = commit_data;
    wr_entry.tag      = commit_tag;
    wr_entry.is_store = commit_is_store;
    wr_entry.seq      = seq_q;
`ifdef COMMIT_TRACE_CYCLE_EN
    wr_entry.cycle    = cycle_q;
`endif
  end

  // NOTE: storage has no reset; the head entry is masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= wr_entry;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      seq_q    <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (pop)    head <= head + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (commit_valid) seq_q <= seq_q + 1'b1;
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef COMMIT_TRACE_CYCLE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cycle_q <= '0;
    else          cycle_q <= cycle_q + 1'b1;
  end
`endif

  always_comb begin
    head_entry = '0;
    if (!empty) head_entry = mem[head];
  end

  assign trace_valid    = !empty;
  assign trace_pc       = head_entry.pc;
  assign trace_rd       = head_entry.rd;
  assign trace_data     = head_entry.data;
  assign trace_tag      = head_entry.tag;
  assign trace_is_store = head_entry.is_store;
  assign trace_seq      = head_entry.seq;
`ifdef COMMIT_TRACE_CYCLE_EN
  assign trace_cycle    = head_entry.cycle;
`endif

endmodule
